// File: rtl/radix4_pkg.sv
// Shared widths, iteration count and FSM encoding for the radix-4 restoring divider.
package radix4_pkg;

    localparam int DW    = 16;
    localparam int VW    = 8;
    localparam int PRW   = 10;
    localparam int NITER = 8;
    localparam int CW    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // 3*y widened to the partial-remainder width; 3*255 = 765 never overflows 10 bits.
    function automatic logic [PRW-1:0] triple_y(input logic [VW-1:0] y_v);
        triple_y = {2'b00, y_v} + {1'b0, y_v, 1'b0};
    endfunction

endpackage

// File: rtl/radix4div_step.sv
// One radix-4 restoring iteration: picks the largest digit k with k*y <= pr and subtracts it.
module radix4div_step
    import radix4_pkg::*;
(
    input  logic [PRW-1:0] pr_i,
    input  logic [VW-1:0]  y_i,
    output logic [1:0]     k_o,
    output logic [PRW-1:0] rem_o
);

    logic [PRW-1:0] y1_s;
    logic [PRW-1:0] y2_s;
    logic [PRW-1:0] y3_s;

    assign y1_s = {2'b00, y_i};
    assign y2_s = {1'b0, y_i, 1'b0};
    assign y3_s = triple_y(y_i);

    // Digit selection from the three parallel 10-bit comparators.
    always_comb begin
        k_o   = 2'd0;
        rem_o = pr_i;
        if (pr_i >= y3_s) begin
            k_o   = 2'd3;
            rem_o = pr_i - y3_s;
        end else if (pr_i >= y2_s) begin
            k_o   = 2'd2;
            rem_o = pr_i - y2_s;
        end else if (pr_i >= y1_s) begin
            k_o   = 2'd1;
            rem_o = pr_i - y1_s;
        end else begin
            k_o   = 2'd0;
            rem_o = pr_i;
        end
    end

endmodule

// File: rtl/radix4div.sv
// Radix-4 restoring divider: 16-bit dividend / 8-bit divisor, 2 quotient bits per cycle.
module radix4div #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] x,
    input  logic [VW-1:0] y,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          dz
);
    import radix4_pkg::*;

    state_e         state_q;
    state_e         state_d;
    logic           busy_q;
    logic           busy_d;
    logic           done_q;
    logic           done_d;
    logic [CW-1:0]  cnt_q;
    logic [PRW-1:0] pr_q;
    logic [DW-1:0]  xq_q;
    logic [VW-1:0]  yq_q;
    logic [DW-1:0]  q_q;
    logic [VW-1:0]  r_q;
    logic           dz_q;

    logic [PRW-1:0] pr_ext_s;
    logic [1:0]     k_s;
    logic [PRW-1:0] rem_s;
    logic           y_zero_s;
    logic           last_iter_s;
    logic           pr_hi_unused_s;

    // xq_q doubles as the quotient register: dividend bits leave at the top, digits enter at the bottom.
    assign pr_ext_s       = {pr_q[VW-1:0], xq_q[DW-1 -: 2]};
    assign y_zero_s       = (y == {VW{1'b0}});
    assign last_iter_s    = (cnt_q == {CW{1'b0}});
    assign pr_hi_unused_s = ^pr_q[PRW-1:VW];

    radix4div_step u_step (
        .pr_i  (pr_ext_s),
        .y_i   (yq_q),
        .k_o   (k_s),
        .rem_o (rem_s)
    );

    // State register plus registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = y_zero_s ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (last_iter_s) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            CALC:    busy_d = 1'b1;
            DONE:    done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
            pr_q  <= {PRW{1'b0}};
            xq_q  <= {DW{1'b0}};
            yq_q  <= {VW{1'b0}};
            q_q   <= {DW{1'b0}};
            r_q   <= {VW{1'b0}};
            dz_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        xq_q  <= x;
                        yq_q  <= y;
                        pr_q  <= {PRW{1'b0}};
                        cnt_q <= CW'(NITER - 1);
                        if (y_zero_s) begin
                            q_q  <= {DW{1'b1}};
                            r_q  <= x[VW-1:0];
                            dz_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    pr_q  <= rem_s;
                    xq_q  <= {xq_q[DW-3:0], k_s};
                    cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    if (last_iter_s) begin
                        q_q  <= {xq_q[DW-3:0], k_s};
                        r_q  <= rem_s[VW-1:0];
                        dz_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_radix4div.sv
// Directed self-checking bench for radix4div: latency, vectors, divide-by-zero, start masking, reset abort, sweep.
module tb_radix4div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic [7:0]  y;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;

    int n_cmp;
    int n_err;

    radix4div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start, wait (bounded) for done; lat = edges after acceptance, -1 on timeout.
    task automatic run_div(input logic [15:0] xv, input logic [7:0] yv,
                           output int lat, output int busy_cnt, output logic done_after);
        start = 1'b1;
        x     = xv;
        y     = yv;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        for (int i = 0; i <= 20; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        x     = 16'd0;
        y     = 8'd0;
        #12;
        n_cmp++;
        if ({busy, done, q, r, dz} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b, want all 0", busy, done, q, r, dz);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int lat, bc;
        logic da;
        run_div(16'd65025, 8'd255, lat, bc, da);
        n_cmp++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL latency: got %0d edges, want 8", lat);
        end
        n_cmp++;
        if (bc !== 8) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d, want 8", bc);
        end
        n_cmp++;
        if (q !== 16'd255 || r !== 8'd0 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL div_65025_255: got q=%0d r=%0d dz=%b, want q=255 r=0 dz=0", q, r, dz);
        end
        n_cmp++;
        if (da !== 1'b0) begin
            n_err++;
            $display("FAIL done_one_cycle: done still %b one cycle later, want 0", da);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] xs [3] = '{16'd1000, 16'd5, 16'd65535};
        logic [7:0]  ys [3] = '{8'd7, 8'd200, 8'd1};
        logic [15:0] qs [3] = '{16'd142, 16'd0, 16'd65535};
        logic [7:0]  rs [3] = '{8'd6, 8'd5, 8'd0};
        int lat, bc;
        logic da;
        for (int i = 0; i < 3; i++) begin
            run_div(xs[i], ys[i], lat, bc, da);
            n_cmp++;
            if (lat !== 8 || q !== qs[i] || r !== rs[i] || dz !== 1'b0) begin
                n_err++;
                $display("FAIL vector%0d: got lat=%0d q=%0d r=%0d dz=%b, want lat=8 q=%0d r=%0d dz=0",
                         i, lat, q, r, dz, qs[i], rs[i]);
            end
        end
    endtask

    task automatic test_divzero();
        int lat, bc;
        logic da;
        run_div(16'h04D2, 8'd0, lat, bc, da);
        n_cmp++;
        if (lat !== 0 || bc !== 0) begin
            n_err++;
            $display("FAIL dz_timing: got lat=%0d busy_cycles=%0d, want 0 and 0", lat, bc);
        end
        n_cmp++;
        if (q !== 16'hFFFF || r !== 8'hD2 || dz !== 1'b1) begin
            n_err++;
            $display("FAIL dz_result: got q=%h r=%h dz=%b, want q=ffff r=d2 dz=1", q, r, dz);
        end
        n_cmp++;
        if (da !== 1'b0) begin
            n_err++;
            $display("FAIL dz_done_pulse: done=%b one cycle later, want 0", da);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        start = 1'b1;
        x     = 16'd1000;
        y     = 8'd7;
        @(posedge clk); #1;
        x   = 16'd5;
        y   = 8'd200;
        lat = -1;
        for (int i = 0; i <= 20; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_cmp++;
        if (lat !== 8 || q !== 16'd142 || r !== 8'd6 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL start_ignored: got lat=%0d q=%0d r=%0d dz=%b, want lat=8 q=142 r=6 dz=0", lat, q, r, dz);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL done_to_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc, seen;
        logic da;
        start = 1'b1;
        x     = 16'd65025;
        y     = 8'd255;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, q, r, dz} !== 27'd0) begin
            n_err++;
            $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h dz=%b, want all 0", busy, done, q, r, dz);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d cycles with busy/done, want 0", seen);
        end
        run_div(16'd1000, 8'd7, lat, bc, da);
        n_cmp++;
        if (lat !== 8 || q !== 16'd142 || r !== 8'd6 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL after_abort: got lat=%0d q=%0d r=%0d dz=%b, want lat=8 q=142 r=6 dz=0", lat, q, r, dz);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] s;
        logic [15:0] xv, dv, eq;
        logic [7:0]  yv, er;
        logic        edz;
        int lat, bc;
        logic da;
        s = 32'd7;
        for (int n = 0; n < 500; n++) begin
            s  = s * 32'd1103515245 + 32'd12345;
            xv = 16'((s >> 16) % 32'd255);
            s  = s * 32'd1103515245 + 32'd12345;
            yv = 8'((s >> 16) % 32'd255);
            dv = xv * {8'd0, yv};
            if (yv == 8'd0) begin
                eq  = 16'hFFFF;
                er  = dv[7:0];
                edz = 1'b1;
            end else begin
                eq  = xv;
                er  = 8'd0;
                edz = 1'b0;
            end
            run_div(dv, yv, lat, bc, da);
            n_cmp++;
            if (lat < 0 || q !== eq || r !== er || dz !== edz) begin
                n_err++;
                $display("FAIL sweep%0d x=%0d y=%0d: got lat=%0d q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                         n, dv, yv, lat, q, r, dz, eq, er, edz);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_latency();
        test_vectors();
        test_divzero();
        test_start_ignored();
        test_reset_abort();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
